pipeline_stall_controller: RTL
==============================

Name: pipeline_stall_controller

Overview:
Consumer end of the pipeline hazard signals. Takes the load-use hazard flag from the hazard detection unit, plus the branch redirect, the memory busy handshakes and the multi-cycle EX busy. Drives every pipeline-register enable and bubble/flush control, so ID/EX, IF/ID and PC stalls are decided in one place. Sits beside the 5-stage CPU pipeline registers. Includes saturating performance counters and a multi-cycle watchdog.

Parameters:
CNT_W, 32, width of each saturating performance counter
MC_TIMEOUT, 64, max consecutive EX_MC_BUSY cycles before MC_TIMEOUT_ERR is set (must be >=1)

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous active-high reset
LU_HAZ_SIG  in  1  load-use hazard from hazard detection unit
EX_BRANCH_TAKEN  in  1  branch/jump in EX redirects PC
IMEM_BUSY  in  1  instruction fetch not yet returned
DMEM_BUSY  in  1  data memory access in MEM not yet complete
EX_MC_BUSY  in  1  multi-cycle FPU/mul-div op occupying EX
CNT_CLEAR  in  1  synchronous clear of counters and MC_TIMEOUT_ERR
PC_EN  out  1  PC register load enable
IF_ID_EN  out  1  IF/ID register enable
IF_ID_FLUSH  out  1  load NOP into IF/ID
ID_EX_EN  out  1  ID/EX register enable
ID_EX_BUBBLE  out  1  load NOP into ID/EX
EX_MEM_EN  out  1  EX/MEM register enable
EX_MEM_BUBBLE  out  1  load NOP into EX/MEM
MEM_WB_EN  out  1  MEM/WB register enable
REDIRECT_PENDING  out  1  high while in REDIRECT_WAIT
MC_TIMEOUT_ERR  out  1  sticky watchdog error
STALL_CYCLES  out  CNT_W  cycles with PC_EN=0
BUBBLE_COUNT  out  CNT_W  cycles with ID_EX_BUBBLE or EX_MEM_BUBBLE
FLUSH_COUNT  out  CNT_W  accepted redirects

Behaviour:
- Reset: state=RUN, counters=0, MC_TIMEOUT_ERR=0, REDIRECT_PENDING=0. While RESET is high, all enables are 0 and all bubble/flush outputs are 0. Reset mid-stall discards any pending redirect.
- Control outputs are combinational from the current inputs and state (zero latency). Counters, state and the error flag are registered.
- Default with no condition active: all *_EN=1, all bubble/flush=0.
- Priority, highest first:
  1. DMEM_BUSY: all *_EN=0, no bubble/flush. The whole pipeline freezes. All other inputs are ignored this cycle.
  2. EX_MC_BUSY: PC_EN, IF_ID_EN and ID_EX_EN = 0. EX_MEM_EN=1 with EX_MEM_BUBBLE=1. MEM_WB_EN=1.
  3. EX_BRANCH_TAKEN: PC_EN=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, remaining EN=1. LU_HAZ_SIG is ignored because the ID instruction is squashed. FLUSH_COUNT increments.
  4. LU_HAZ_SIG: PC_EN=0, IF_ID_EN=0, ID_EX_BUBBLE=1, remaining EN=1. This produces exactly one bubble per hazard cycle.
  5. IMEM_BUSY: PC_EN=0, IF_ID_FLUSH=1, remaining EN=1.
- FSM states: RUN, MC_WAIT, REDIRECT_WAIT.
  - RUN -> MC_WAIT: EX_MC_BUSY=1 and DMEM_BUSY=0.
  - MC_WAIT -> RUN: EX_MC_BUSY=0.
  - RUN -> REDIRECT_WAIT: a branch is accepted (priority 3) while IMEM_BUSY=1. The in-flight fetch belongs to the wrong path.
  - REDIRECT_WAIT -> RUN: first cycle with IMEM_BUSY=0 and DMEM_BUSY=0. That cycle forces IF_ID_FLUSH=1 and PC_EN=0 so the returned wrong-path word is dropped and the target is refetched. This override sits at priority 2.5, below EX_MC_BUSY and above branch.
  - A second branch in REDIRECT_WAIT stays in REDIRECT_WAIT, loads the new PC and increments FLUSH_COUNT.
- Watchdog: an internal counter of width clog2(MC_TIMEOUT+1) counts consecutive EX_MC_BUSY cycles (held during DMEM_BUSY) and clears when EX_MC_BUSY drops. When the count reaches MC_TIMEOUT, MC_TIMEOUT_ERR is set. It stays set until RESET or CNT_CLEAR. The stall continues regardless.
- Counters saturate at all-ones and never wrap. CNT_CLEAR has priority over increment in the same cycle.

Decomposition:
- Shared package cpu_ctrl_pkg: FSM state encoding (RUN=2'd0, MC_WAIT=2'd1, REDIRECT_WAIT=2'd2) and the priority-level constants reused by the forwarding/hazard blocks.
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated three times.

Test Plan:
- RESET high mid-MC_WAIT with EX_MC_BUSY=1 -> all EN=0 during reset. After release: state=RUN, counters=0, REDIRECT_PENDING=0.
- LU_HAZ_SIG=1 for one cycle -> PC_EN=0, IF_ID_EN=0, ID_EX_BUBBLE=1 that cycle. STALL_CYCLES=1 and BUBBLE_COUNT=1 afterwards.
- DMEM_BUSY=1 for 3 cycles together with LU_HAZ_SIG=1 and EX_BRANCH_TAKEN=1 -> all outputs 0 for 3 cycles, no counter change except STALL_CYCLES+=3.
- EX_BRANCH_TAKEN=1 with IMEM_BUSY=1, then IMEM_BUSY=1 for 2 more cycles, then 0 -> REDIRECT_PENDING high 3 cycles. On the drop cycle IF_ID_FLUSH=1 and PC_EN=0. FLUSH_COUNT=1.
- MC_TIMEOUT=4, EX_MC_BUSY held 6 cycles -> EX_MEM_BUBBLE=1 every cycle, MC_TIMEOUT_ERR rises after the 4th cycle, then CNT_CLEAR=1 -> error and counters return to 0.
- CNT_W=2, 5 consecutive LU_HAZ_SIG cycles -> BUBBLE_COUNT saturates at 3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the pipeline control blocks:
//   - stall_state_t : stall controller FSM encoding
//   - stall_level_t : resolved hazard priority level (highest first)
//   - pipe_ctrl_t   : bundle of pipeline-register enable/bubble/flush controls
//   - resolve_level : picks the winning hazard level from the raw conditions
//   - ctrl_for_level: maps a hazard level onto the pipeline control bundle
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        MC_WAIT       = 2'd1,
        REDIRECT_WAIT = 2'd2
    } stall_state_t;

    // Ordered by priority. LVL_REDIRECT is the refetch after a redirect whose
    // wrong-path fetch has just returned; it ranks between the multi-cycle
    // stall and a fresh branch.
    typedef enum logic [2:0] {
        LVL_NONE      = 3'd0,
        LVL_DMEM      = 3'd1,
        LVL_MC        = 3'd2,
        LVL_REDIRECT  = 3'd3,
        LVL_BRANCH    = 3'd4,
        LVL_LOAD_USE  = 3'd5,
        LVL_IMEM      = 3'd6
    } stall_level_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic ex_mem_bubble;
        logic mem_wb_en;
    } pipe_ctrl_t;

    function automatic stall_level_t resolve_level(
        input logic dmem_busy,
        input logic mc_busy,
        input logic redirect_done,
        input logic branch_taken,
        input logic load_use,
        input logic imem_busy
    );
        if (dmem_busy)          return LVL_DMEM;
        else if (mc_busy)       return LVL_MC;
        else if (redirect_done) return LVL_REDIRECT;
        else if (branch_taken)  return LVL_BRANCH;
        else if (load_use)      return LVL_LOAD_USE;
        else if (imem_busy)     return LVL_IMEM;
        else                    return LVL_NONE;
    endfunction

    function automatic pipe_ctrl_t ctrl_for_level(input stall_level_t lvl);
        pipe_ctrl_t c;
        // Free-running pipeline unless a level overrides individual fields
        c.pc_en         = 1'b1;
        c.if_id_en      = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_en      = 1'b1;
        c.id_ex_bubble  = 1'b0;
        c.ex_mem_en     = 1'b1;
        c.ex_mem_bubble = 1'b0;
        c.mem_wb_en     = 1'b1;
        case (lvl)
            LVL_DMEM: begin
                c = '0;
            end
            LVL_MC: begin
                // Front end holds; the MC op stays in ID/EX while bubbles
                // drain into EX/MEM so older instructions can retire.
                c.pc_en         = 1'b0;
                c.if_id_en      = 1'b0;
                c.id_ex_en      = 1'b0;
                c.ex_mem_bubble = 1'b1;
            end
            LVL_REDIRECT: begin
                // Drop the returned wrong-path word and refetch the target
                c.pc_en       = 1'b0;
                c.if_id_flush = 1'b1;
            end
            LVL_BRANCH: begin
                c.if_id_flush  = 1'b1;
                c.id_ex_bubble = 1'b1;
            end
            LVL_LOAD_USE: begin
                c.pc_en        = 1'b0;
                c.if_id_en     = 1'b0;
                c.id_ex_bubble = 1'b1;
            end
            LVL_IMEM: begin
                c.pc_en       = 1'b0;
                c.if_id_flush = 1'b1;
            end
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (count -> 0)
//   inc   - increment by one this cycle (ignored once at all-ones)
//   clr   - synchronous clear, wins over inc
//   count - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Stick at all-ones rather than wrapping so overflowed stats stay obvious
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush decision point for the 5-stage pipeline. Combines the
// load-use hazard, branch redirect, memory busy handshakes and multi-cycle EX
// busy into every pipeline-register enable and bubble/flush control. Also
// keeps saturating performance counters and a multi-cycle watchdog.
// Ports:
//   CLK, RESET            - clock; asynchronous active-high reset
//   LU_HAZ_SIG            - load-use hazard from hazard detection
//   EX_BRANCH_TAKEN       - branch/jump in EX redirects the PC
//   IMEM_BUSY, DMEM_BUSY  - instruction / data memory not yet complete
//   EX_MC_BUSY            - multi-cycle op occupying EX
//   CNT_CLEAR             - synchronous clear of counters and watchdog error
//   PC_EN .. MEM_WB_EN    - pipeline register enables, bubbles and flush
//   REDIRECT_PENDING      - a redirect is waiting on a wrong-path fetch
//   MC_TIMEOUT_ERR        - sticky multi-cycle watchdog error
//   STALL_CYCLES, BUBBLE_COUNT, FLUSH_COUNT - saturating statistics
// -----------------------------------------------------------------------------
module pipeline_stall_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LU_HAZ_SIG,
    input  logic             EX_BRANCH_TAKEN,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    input  logic             EX_MC_BUSY,
    input  logic             CNT_CLEAR,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_EN,
    output logic             ID_EX_BUBBLE,
    output logic             EX_MEM_EN,
    output logic             EX_MEM_BUBBLE,
    output logic             MEM_WB_EN,
    output logic             REDIRECT_PENDING,
    output logic             MC_TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [CNT_W-1:0] BUBBLE_COUNT,
    output logic [CNT_W-1:0] FLUSH_COUNT
);

    localparam int MC_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [MC_W-1:0] MC_LIMIT = MC_W'(MC_TIMEOUT);
    localparam logic [MC_W-1:0] MC_LAST  = MC_W'(MC_TIMEOUT - 1);

    stall_state_t    state;
    stall_state_t    state_next;
    stall_level_t    level;
    pipe_ctrl_t      ctrl;
    logic            redirect_done;
    logic            branch_accept;
    logic [MC_W-1:0] mc_cnt;
    logic            mc_err;
    logic            mc_hit;

    // The wrong-path fetch has returned, so this is the cycle to refetch
    assign redirect_done = (state == REDIRECT_WAIT) && !IMEM_BUSY;

    assign level         = resolve_level(DMEM_BUSY, EX_MC_BUSY, redirect_done,
                                         EX_BRANCH_TAKEN, LU_HAZ_SIG, IMEM_BUSY);
    assign branch_accept = (level == LVL_BRANCH);

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and zero-latency control outputs. Reset forces a full
    // freeze so nothing is clocked into the pipeline while it is held.
    always_comb begin
        state_next = state;
        ctrl       = ctrl_for_level(level);
        if (RESET) begin
            ctrl = '0;
        end
        case (state)
            RUN: begin
                if (level == LVL_MC) begin
                    state_next = MC_WAIT;
                end else if (branch_accept && IMEM_BUSY) begin
                    state_next = REDIRECT_WAIT;
                end
            end
            MC_WAIT: begin
                // A branch accepted on the release cycle behaves as from RUN
                if (!EX_MC_BUSY) begin
                    state_next = (branch_accept && IMEM_BUSY) ? REDIRECT_WAIT : RUN;
                end
            end
            REDIRECT_WAIT: begin
                // A further branch here needs IMEM_BUSY, so it stays put
                if (level == LVL_REDIRECT) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Watchdog: counts consecutive multi-cycle busy cycles, frozen while the
    // data memory stalls everything. The error only flags; it never unstalls.
    assign mc_hit = EX_MC_BUSY && !DMEM_BUSY && (mc_cnt == MC_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mc_cnt <= '0;
            mc_err <= 1'b0;
        end else begin
            if (!EX_MC_BUSY) begin
                mc_cnt <= '0;
            end else if (!DMEM_BUSY && (mc_cnt != MC_LIMIT)) begin
                mc_cnt <= mc_cnt + MC_W'(1);
            end
            if (CNT_CLEAR) begin
                mc_err <= 1'b0;
            end else if (mc_hit) begin
                mc_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (!ctrl.pc_en),
        .clr   (CNT_CLEAR),
        .count (STALL_CYCLES)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (ctrl.id_ex_bubble || ctrl.ex_mem_bubble),
        .clr   (CNT_CLEAR),
        .count (BUBBLE_COUNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .inc   (branch_accept),
        .clr   (CNT_CLEAR),
        .count (FLUSH_COUNT)
    );

    assign PC_EN            = ctrl.pc_en;
    assign IF_ID_EN         = ctrl.if_id_en;
    assign IF_ID_FLUSH      = ctrl.if_id_flush;
    assign ID_EX_EN         = ctrl.id_ex_en;
    assign ID_EX_BUBBLE     = ctrl.id_ex_bubble;
    assign EX_MEM_EN        = ctrl.ex_mem_en;
    assign EX_MEM_BUBBLE    = ctrl.ex_mem_bubble;
    assign MEM_WB_EN        = ctrl.mem_wb_en;
    assign REDIRECT_PENDING = (state == REDIRECT_WAIT);
    assign MC_TIMEOUT_ERR   = mc_err;

endmodule
